// File: rtl/bus_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bus_pkg: shared req/ack bus types for the crossbar and its slaves     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/slave_sp_ram.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | slave_sp_ram: single-port synchronous RAM with registered read        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module slave_sp_ram
  import bus_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];

  // Read-before-write: rdata shows the old word on a write cycle
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
    rdata <= mem_q[idx];
  end

endmodule
`default_nettype wire

// File: rtl/mem_slave_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_slave_responder: RAM-backed req/ack slave with wait states.       |
// | Optional MEM_SLAVE_RANDOM_WAIT_EN adds LFSR-driven extra wait states. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module mem_slave_responder
  import bus_pkg::*;
#(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              cmd,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata
);

  // Wide enough for WAIT_CYCLES(15) plus the random extra (3)
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] c_wait = CNT_W'(WAIT_CYCLES);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_ram_we;
  logic [DATA_W-1:0]     w_ram_rdata;
  logic [CNT_W-1:0]      w_wait_total;
  logic                  w_unused_addr;

  assign w_idx         = addr[DEPTH_LOG2+1:2];
  assign w_unused_addr = ^{addr[ADDR_W-1:DEPTH_LOG2+2], addr[1:0]};
  assign w_ram_we      = (state_q == ACK) && (cmd == CMD_WRITE);

`ifdef MEM_SLAVE_RANDOM_WAIT_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign w_wait_total = c_wait + {{(CNT_W-2){1'b0}}, lfsr_q[1:0]};
`else
  assign w_wait_total = c_wait;
`endif

  slave_sp_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk  (clk),
    .we   (w_ram_we),
    .idx  (w_idx),
    .wdata(wdata),
    .rdata(w_ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
`ifdef MEM_SLAVE_RANDOM_WAIT_EN
    lfsr_d  = lfsr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (w_wait_total == '0) begin
            state_d = ACK;
          end else begin
            cnt_d   = w_wait_total - CNT_W'(1);
            state_d = WAIT;
          end
`ifdef MEM_SLAVE_RANDOM_WAIT_EN
          lfsr_d = lfsr_next(lfsr_q);
`endif
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK: begin
        // The transaction completes even if req was dropped during ACK
        state_d = IDLE;
        if (cmd == CMD_READ) begin
          rdata_d = w_ram_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
    ack_d = (state_d == ACK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
`ifdef MEM_SLAVE_RANDOM_WAIT_EN
      lfsr_q  <= LFSR_SEED;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
`ifdef MEM_SLAVE_RANDOM_WAIT_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_slave_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mem_slave_responder: directed + random checks of two instances     |
// | (WAIT_CYCLES = 2 and WAIT_CYCLES = 0). Rev 1.0                        |
// +-----------------------------------------------------------------------+
module tb_mem_slave_responder;
  import bus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, req, cmd, ack;
  logic [1:0][31:0] addr, wdata, rdata;

  mem_slave_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst(rst[0]), .req(req[0]), .addr(addr[0]), .cmd(cmd[0]),
    .wdata(wdata[0]), .ack(ack[0]), .rdata(rdata[0]));

  mem_slave_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst[1]), .req(req[1]), .addr(addr[1]), .cmd(cmd[1]),
    .wdata(wdata[1]), .ack(ack[1]), .rdata(rdata[1]));

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  int          base_wait [2] = '{2, 0};
  logic [31:0] mem_m     [2][256];
  logic [15:0] lfsr_m    [2];
  logic [31:0] rdata_m   [2];
  int          known_q   [$];

  logic [31:0] b_addr [16];
  logic [31:0] b_data [16];
  logic        b_cmd  [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % 256);
  endfunction

  function automatic logic [15:0] ref_lfsr_step(input logic [15:0] s);
    int  taps [4] = '{16, 14, 13, 11};
    logic fb = 1'b0;
    foreach (taps[t]) fb ^= s[taps[t]-1];
    return {s[14:0], fb};
  endfunction

  // Wait states the model predicts for the next accepted request
  function automatic int model_wait(input int i);
    int w = base_wait[i];
`ifdef MEM_SLAVE_RANDOM_WAIT_EN
    w += int'(lfsr_m[i] % 4);
    lfsr_m[i] = ref_lfsr_step(lfsr_m[i]);
`endif
    return w;
  endfunction

  function automatic void model_commit(input int i, input logic c, input logic [31:0] a,
                                       input logic [31:0] d);
    if (c) mem_m[i][word_of(a)] = d;
    else   rdata_m[i] = mem_m[i][word_of(a)];
  endfunction

  // Single transaction, entered and left on a falling edge
  task automatic txn(input int i, input logic c, input logic [31:0] a,
                     input logic [31:0] d, input string tag);
    int exp_w, lat;
    exp_w = model_wait(i);
    addr[i] = a; cmd[i] = c; wdata[i] = d; req[i] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ack[i]) begin lat = k; break; end
    end
    req[i] = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_w + 1));
    @(negedge clk);
    check({tag, " ack width"}, 32'(ack[i]), 32'd0);
    model_commit(i, c, a, d);
    check({tag, " rdata"}, rdata[i], rdata_m[i]);
  endtask

  // n transactions with req held high throughout
  task automatic burst(input int i, input int n, input string tag);
    int exp_w, cyc, prev, found;
    cyc = 0; prev = 0;
    addr[i] = b_addr[0]; cmd[i] = b_cmd[0]; wdata[i] = b_data[0]; req[i] = 1'b1;
    for (int j = 0; j < n; j++) begin
      exp_w = model_wait(i);
      found = 0;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        cyc++;
        if (ack[i]) begin found = 1; break; end
      end
      if (j == 0) check({tag, " first ack"}, 32'(found ? cyc : -1), 32'(exp_w + 1));
      else        check({tag, " ack gap"}, 32'(found ? cyc - prev : -1), 32'(exp_w + 2));
      prev = cyc;
      @(negedge clk);
      cyc++;
      check({tag, " ack width"}, 32'(ack[i]), 32'd0);
      model_commit(i, b_cmd[j], b_addr[j], b_data[j]);
      check({tag, " rdata"}, rdata[i], rdata_m[i]);
      if (j + 1 < n) begin
        addr[i] = b_addr[j+1]; cmd[i] = b_cmd[j+1]; wdata[i] = b_data[j+1];
      end else begin
        req[i] = 1'b0;
      end
    end
  endtask

  initial begin
    int found;
    logic [31:0] a, d;
    rst = 2'b11; req = '0; cmd = '0; addr = '0; wdata = '0;
    lfsr_m[0] = 16'hACE1; lfsr_m[1] = 16'hACE1;
    rdata_m[0] = '0; rdata_m[1] = '0;
    #2;
    check("reset ack", 32'(ack[0]), 32'd0);
    check("reset rdata", rdata[0], 32'd0);
    check("reset ack w0", 32'(ack[1]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 2'b00;

    // Write then read
    txn(0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, "t1 wr");
    txn(0, 1'b0, 32'h0000_0010, 32'h0, "t1 rd");
    check("t1 readback", rdata[0], 32'hDEADBEEF);

    // Byte offset and upper-address aliasing
    txn(0, 1'b1, 32'h0000_0013, 32'h0000_1111, "t2 wr off");
    txn(0, 1'b0, 32'h0000_0010, 32'h0, "t2 rd off");
    check("t2 offset", rdata[0], 32'h0000_1111);
    txn(0, 1'b1, 32'h4000_0400, 32'h0000_2222, "t2 wr alias");
    txn(0, 1'b0, 32'h0000_0000, 32'h0, "t2 rd alias");
    check("t2 alias", rdata[0], 32'h0000_2222);

    // Abort during WAIT
    txn(0, 1'b1, 32'h0000_0020, 32'hAAAA_0000, "t3 prior");
    void'(model_wait(0));
    addr[0] = 32'h20; cmd[0] = 1'b1; wdata[0] = 32'h5555_5555; req[0] = 1'b1;
    @(negedge clk);
    check("t3 no ack in wait", 32'(ack[0]), 32'd0);
    req[0] = 1'b0;
    found = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack[0]) found = 1;
    end
    check("t3 no ack after abort", 32'(found), 32'd0);
    txn(0, 1'b0, 32'h0000_0020, 32'h0, "t3 rd");
    check("t3 prior kept", rdata[0], 32'hAAAA_0000);

    // Asynchronous reset while in WAIT
    void'(model_wait(0));
    addr[0] = 32'h30; cmd[0] = 1'b1; wdata[0] = 32'h7777_7777; req[0] = 1'b1;
    @(negedge clk);
    #1 rst[0] = 1'b1;
    #1;
    check("t4 wait rst ack", 32'(ack[0]), 32'd0);
    check("t4 wait rst rdata", rdata[0], 32'd0);
    req[0] = 1'b0;
    #1 rst[0] = 1'b0;
    lfsr_m[0] = 16'hACE1; rdata_m[0] = '0;
    @(negedge clk);
    txn(0, 1'b1, 32'h0000_0030, 32'h8888_8888, "t4 post rst wr");

    // Asynchronous reset while ack is high: the write must be dropped
    void'(model_wait(0));
    addr[0] = 32'h30; cmd[0] = 1'b1; wdata[0] = 32'h9999_9999; req[0] = 1'b1;
    found = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ack[0]) begin found = 1; break; end
    end
    check("t4 ack seen", 32'(found), 32'd1);
    #1 rst[0] = 1'b1;
    #1;
    check("t4 ack rst ack", 32'(ack[0]), 32'd0);
    req[0] = 1'b0;
    #1 rst[0] = 1'b0;
    lfsr_m[0] = 16'hACE1; rdata_m[0] = '0;
    @(negedge clk);
    txn(0, 1'b0, 32'h0000_0030, 32'h0, "t4 rd");
    check("t4 write dropped", rdata[0], 32'h8888_8888);

    // Back-to-back writes, zero wait states
    for (int j = 0; j < 4; j++) begin
      b_addr[j] = 32'h100 + 32'(4 * j);
      b_data[j] = $urandom;
      b_cmd[j]  = 1'b1;
    end
    burst(1, 4, "t5 b2b");
    for (int j = 0; j < 4; j++) txn(1, 1'b0, 32'h100 + 32'(4 * j), 32'h0, "t5 rd");

    // Random traffic on the waited instance
    for (int w = 0; w < 256; w++) if (mem_m[0][w] !== 32'hx) known_q.push_back(w);
    for (int n = 0; n < 24; n++) begin
      if (known_q.size() == 0 || $urandom_range(0, 1) == 0) begin
        a = $urandom;
        d = $urandom;
        if (!(word_of(a) inside {known_q})) known_q.push_back(word_of(a));
        txn(0, 1'b1, a, d, "rand wr");
      end else begin
        a = ($urandom & 32'hFFFF_FC03) | (32'(known_q[$urandom_range(0, known_q.size() - 1)]) << 2);
        txn(0, 1'b0, a, 32'h0, "rand rd");
      end
    end

    // Sixteen reads with req held high
    for (int j = 0; j < 16; j++) begin
      b_addr[j] = (32'($urandom) & 32'hFFFF_FC03) |
                  (32'(known_q[$urandom_range(0, known_q.size() - 1)]) << 2);
      b_data[j] = 32'h0;
      b_cmd[j]  = 1'b0;
    end
    burst(0, 16, "t6 reads");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
